// File: rtl/des_rev_key_schedule_if.sv
`default_nettype none
// ============================================================================
// Module      : des_rev_key_schedule_if
// Description : Key-in / subkey-out handshake bundle for the reverse
//               (decryption-order) DES key schedule.
//               master = key schedule block, slave = its environment.
// Revision    : 1.0  initial release
// ============================================================================
interface des_rev_key_schedule_if;
    logic [63:0] key;           // DES key, bit 63 = DES bit 1
    logic        key_valid;
    logic        key_ready;
    logic [47:0] subkey;
    logic        subkey_valid;
    logic        subkey_ready;
    logic [3:0]  round_idx;     // 15 = K16 ... 0 = K1
    logic        last;
    logic        parity_err;

    modport master (
        input  key, key_valid, subkey_ready,
        output key_ready, subkey, subkey_valid, round_idx, last, parity_err
    );

    modport slave (
        output key, key_valid, subkey_ready,
        input  key_ready, subkey, subkey_valid, round_idx, last, parity_err
    );
endinterface
`default_nettype wire

// File: rtl/des_rev_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : des_rev_key_schedule
// Description : DES key schedule producing the 16 round subkeys in
//               decryption order (K16 first, K1 last), one per accepted
//               handshake. C/D halves are right-rotated so no pre-computation
//               pass is needed: C16/D16 equal C0/D0.
//               Optional feature macro: DES_KEY_PARITY_CHECK_EN
//               (sticky odd-parity check of the key bytes).
// Revision    : 1.0  initial release
// ============================================================================
module des_rev_key_schedule (
    input  logic                          clk,
    input  logic                          rst,   // asynchronous, active-low
    des_rev_key_schedule_if.master        bus
);

    // Permuted choice 1: DES bit numbers (1 = MSB of key) selected into C||D.
    localparam logic [6:0] PC1_TAB [56] = '{
        7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
        7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
        7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
        7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
        7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
        7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
        7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
        7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
    };

    // Permuted choice 2: positions (1 = MSB of C||D) selected into the subkey.
    localparam logic [5:0] PC2_TAB [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    function automatic logic [55:0] pc1(input logic [63:0] k);
        logic [1:64] kb;
        logic [1:56] r;
        kb = k;
        r  = '0;
        for (int i = 0; i < 56; i++) begin
            r[i + 1] = kb[PC1_TAB[i]];
        end
        return r;
    endfunction

    function automatic logic [47:0] pc2(input logic [55:0] cd);
        logic [1:56] cb;
        logic [1:48] r;
        cb = cd;
        r  = '0;
        for (int i = 0; i < 48; i++) begin
            r[i + 1] = cb[PC2_TAB[i]];
        end
        return r;
    endfunction

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        accept;
    logic        advance;

    logic [27:0] c_half;
    logic [27:0] d_half;
    logic [27:0] c_rot;
    logic [27:0] d_rot;
    logic        one_step;
    logic [55:0] key_pc1;
    logic [47:0] subkey_reg;
    logic [3:0]  round_cnt;

    // State register; reset abandons any schedule in progress.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        advance    = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.key_valid) begin
                    accept     = 1'b1;
                    next_state = EMIT;
                end
            end
            EMIT: begin
                if (bus.subkey_ready) begin
                    if (round_cnt == 4'd0) begin
                        next_state = IDLE;
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Reverse rotation: going from K(n) to K(n-1) undoes the left shift s[n],
    // which is a single position only for n = 2, 9 and 16.
    always_comb begin
        one_step = (round_cnt == 4'd1) || (round_cnt == 4'd8) || (round_cnt == 4'd15);
        c_rot    = one_step ? {c_half[0], c_half[27:1]} : {c_half[1:0], c_half[27:2]};
        d_rot    = one_step ? {d_half[0], d_half[27:1]} : {d_half[1:0], d_half[27:2]};
        key_pc1  = pc1(bus.key);
    end

    // C/D halves, current subkey and its round index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            c_half     <= '0;
            d_half     <= '0;
            subkey_reg <= '0;
            round_cnt  <= 4'd0;
        end else if (accept) begin
            c_half     <= key_pc1[55:28];
            d_half     <= key_pc1[27:0];
            subkey_reg <= pc2(key_pc1);
            round_cnt  <= 4'd15;
        end else if (advance) begin
            c_half     <= c_rot;
            d_half     <= d_rot;
            subkey_reg <= pc2({c_rot, d_rot});
            round_cnt  <= round_cnt - 4'd1;
        end
    end

    assign bus.key_ready    = (state == IDLE);
    assign bus.subkey_valid = (state == EMIT);
    assign bus.subkey       = subkey_reg;
    assign bus.round_idx    = round_cnt;
    assign bus.last         = (state == EMIT) && (round_cnt == 4'd0);

`ifdef DES_KEY_PARITY_CHECK_EN
    // True when any key byte carries an even number of ones.
    function automatic logic any_even_byte(input logic [63:0] k);
        logic err;
        err = 1'b0;
        for (int b = 0; b < 8; b++) begin
            if (~^k[8*b +: 8]) begin
                err = 1'b1;
            end
        end
        return err;
    endfunction

    logic parity_flag;

    // Sticky parity flag, only updated when a key is accepted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            parity_flag <= 1'b0;
        end else if (accept && any_even_byte(bus.key)) begin
            parity_flag <= 1'b1;
        end
    end

    assign bus.parity_err = parity_flag;
`else
    // Parity bits are dropped by PC-1 and have no other consumer here.
    logic unused_parity_bits;
    assign unused_parity_bits = ^{bus.key[56], bus.key[48], bus.key[40], bus.key[32],
                                  bus.key[24], bus.key[16], bus.key[8],  bus.key[0]};
    assign bus.parity_err     = 1'b0;
`endif

endmodule
`default_nettype wire
